dadda16_seq_ctrl: RTL

//  - Sequencer that builds a 16x16 unsigned multiply from one shared dadda_8 instance over up to 4 cycles.
//  - Accepts operands and a tag on a valid/ready input channel. Returns the 32-bit product and the tag on a valid/ready output channel.
//  - Sits between an operand-issuing datapath and the combinational dadda_8 core. It owns the operand half-select muxes, the shift/accumulate and the step FSM.

---
 rtl/dadda16_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dadda16_seq_ctrl.sv
// rtl/dadda16_seq_ctrl.sv - 16x16 unsigned multiply sequenced over one shared 8x8 core
// Optional perf counters (perf_ops, perf_busy) are built when DADDA16_PERF_CNT_EN is defined.

module dadda_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] s;
    logic [15:0] c;
    logic [15:0] pp;
    logic [15:0] t;

    // Carry-save reduction of the partial-product rows, then a single carry-propagate add
    always_comb begin
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        for (int i = 0; i < 8; i++) begin
            pp = b[i] ? (16'(a) << i) : 16'd0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        p = s + c;
    end
endmodule

module dadda16_seq_ctrl #(
    parameter int SKIP_ZERO = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prod,
    output logic [TAG_W-1:0] out_tag
`ifdef DADDA16_PERF_CNT_EN
    ,
    output logic [15:0]      perf_ops,
    output logic [31:0]      perf_busy
`endif
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state;
    logic [15:0]      a_r;
    logic [15:0]      b_r;
    logic [TAG_W-1:0] tag_r;
    logic [3:0]       mask_r;
    logic [1:0]       step;
    logic [31:0]      acc;

    logic [3:0]       in_mask;
    logic [7:0]       op_x;
    logic [7:0]       op_y;
    logic [15:0]      k;
    logic [31:0]      term;
    logic [3:0]       rest;

    // mask bit order: {AH*BH, AH*BL, AL*BH, AL*BL}
    function automatic logic [3:0] step_mask(input logic [15:0] a, input logic [15:0] b);
        logic al;
        logic ah;
        logic bl;
        logic bh;
        al = |a[7:0];
        ah = |a[15:8];
        bl = |b[7:0];
        bh = |b[15:8];
        return {ah & bh, ah & bl, al & bh, al & bl};
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    assign in_mask = (SKIP_ZERO != 0) ? step_mask(in_a, in_b) : 4'b1111;

    // step[1] picks the A half, step[0] the B half; shift is 8 per high half
    assign op_x = step[1] ? a_r[15:8] : a_r[7:0];
    assign op_y = step[0] ? b_r[15:8] : b_r[7:0];
    assign term = 32'(k) << {step[1] & step[0], step[1] ^ step[0], 3'b000};
    assign rest = mask_r & (4'b1110 << step);

    dadda_8 u_core (
        .a (op_x),
        .b (op_y),
        .p (k)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_tag   <= '0;
            acc       <= '0;
            step      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            tag_r     <= '0;
            mask_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        tag_r    <= in_tag;
                        mask_r   <= in_mask;
                        step     <= first_set(in_mask);
                        acc      <= '0;
                        in_ready <= 1'b0;
                        state    <= (in_mask == 4'b0000) ? DONE : MUL;
                    end
                end
                MUL: begin
                    acc <= acc + term;
                    if (rest == 4'b0000) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_prod  <= acc + term;
                        out_tag   <= tag_r;
                    end else begin
                        step <= first_set(rest);
                    end
                end
                DONE: begin
                    // An all-zero request lands here with out_valid low, giving it a 1-cycle latency too
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_prod  <= acc;
                        out_tag   <= tag_r;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DADDA16_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_ops <= perf_ops + 16'd1;
            end
            if (state != IDLE) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`endif
endmodule
